// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t    : FSM encoding IDLE=0, RUN=1, DONE=2
//   MULT_WIDTH : default operand width
//   CNT_W      : iteration counter width for MULT_WIDTH
//   cnt_width  : counter width for an arbitrary operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_WIDTH = 32;
  localparam int CNT_W      = $clog2(MULT_WIDTH);

  // Keeps the counter at least one bit wide for degenerate widths.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Control FSM and iteration counter for the shift-add multiplier.
// Ports:
//   clk    in   rising-edge clock
//   clear  in   synchronous active-high reset
//   start  in   request, honoured only in IDLE
//   state  out  current FSM state (also used by the datapath for start acceptance)
//   run    out  high in RUN: datapath performs one iteration per cycle
//   last   out  high in the final RUN cycle (count == WIDTH-1)
//   busy   out  high in RUN and DONE
//   done   out  high for the single DONE cycle
// Handshake: start is a request with no ready; it is taken only when state is IDLE
// and clear is low, and is dropped (not queued) in any other state.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic   clk,
  input  logic   clear,
  input  logic   start,
  output state_t state,
  output logic   run,
  output logic   last,
  output logic   busy,
  output logic   done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      RUN: begin
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d = DONE;
          count_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state = state_q;
  assign run   = (state_q == RUN);
  assign last  = run && (count_q == LAST_CNT);
  assign done  = (state_q == DONE);
  assign busy  = run || done;

endmodule

// File: rtl/seq_mult_32.sv
// Multi-cycle shift-add multiplier feeding the HI/LO register pair.
// One multiplier bit is consumed per cycle; after WIDTH RUN cycles the product
// appears on prod_hi/prod_lo together with a one-cycle done/load strobe.
// Ports:
//   clk      in   rising-edge clock
//   clear    in   synchronous active-high reset
//   start    in   request, sampled only in IDLE
//   a, b     in   multiplicand / multiplier, captured on accepted start
//   busy     out  high in RUN and DONE
//   done     out  one-cycle pulse, product valid
//   load     out  same as done; drives HI.Load and LO.Load
//   prod_hi  out  upper half of product (registered, held until next DONE or clear)
//   prod_lo  out  lower half of product (registered, held until next DONE or clear)
// Configuration macro: MUL_SIGNED_EN -- when defined, a and b are two's complement;
// magnitudes are multiplied and the result negated if the operand signs differ.
module seq_mult_32
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             load,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  state_t ctrl_state;
  logic   run, last, accept;

  mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk   (clk),
    .clear (clear),
    .start (start),
    .state (ctrl_state),
    .run   (run),
    .last  (last),
    .busy  (busy),
    .done  (done)
  );

  assign accept = (ctrl_state == IDLE) && start;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;   // low half of the accumulator, shares bits with the multiplier
  logic [WIDTH-1:0] acc_q, acc_d;         // high half of the accumulator
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

  logic [WIDTH-1:0]   add_val;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   next_hi, next_lo;
  logic [2*WIDTH-1:0] prod_full;
  logic [WIDTH-1:0]   op_a, op_b;

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;
  always_comb begin
    op_a  = a[WIDTH-1] ? -a : a;
    op_b  = b[WIDTH-1] ? -b : b;
    neg_d = neg_q;
    if (accept) neg_d = a[WIDTH-1] ^ b[WIDTH-1];
  end
  always_ff @(posedge clk) begin
    if (clear) neg_q <= 1'b0;
    else       neg_q <= neg_d;
  end
`else
  always_comb begin
    op_a = a;
    op_b = b;
  end
`endif

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;

    add_val = mplier_q[0] ? mcand_q : '0;
    sum     = {1'b0, acc_q} + {1'b0, add_val};
    // Shift {carry, acc, multiplier} right by one.
    next_hi = sum[WIDTH:1];
    next_lo = {sum[0], mplier_q[WIDTH-1:1]};
`ifdef MUL_SIGNED_EN
    prod_full = neg_q ? -{next_hi, next_lo} : {next_hi, next_lo};
`else
    prod_full = {next_hi, next_lo};
`endif

    if (accept) begin
      mcand_d  = op_a;
      mplier_d = op_b;
      acc_d    = '0;
    end else if (run) begin
      acc_d    = next_hi;
      mplier_d = next_lo;
      // The result registers change only on the edge that enters DONE.
      if (last) begin
        prod_hi_d = prod_full[2*WIDTH-1:WIDTH];
        prod_lo_d = prod_full[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
    end
  end

  assign prod_hi = prod_hi_q;
  assign prod_lo = prod_lo_q;
  assign load    = done;

endmodule
